// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Multi-channel push-button conditioner. Each raw key pin is
//            synchronised with two flops and filtered by a per-channel
//            four-state FSM. A level change is accepted only after it has
//            been stable for CNT_MAX cycles. Outputs are all registered:
//            a debounced level in pin polarity plus one-cycle press and
//            release pulses.
//
// Ports    : clk         - system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            key_in      - raw asynchronous key pins      [KEY_NUM]
//            key_out     - debounced level, pin polarity  [KEY_NUM]
//            key_press   - 1-cycle pulse on accepted press    [KEY_NUM]
//            key_release - 1-cycle pulse on accepted release  [KEY_NUM]
//            key_long    - 1-cycle long-press pulse           [KEY_NUM]
//                          (only when KEY_LONG_PRESS_EN is defined)
//
// Options  : KEY_LONG_PRESS_EN - adds the key_long port and a per-channel
//            long-press counter (threshold LONG_MS).
//
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int KEY_NUM        = 2,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LONG_MS        = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_out,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic [KEY_NUM-1:0] key_long
`endif
);

  localparam int   c_cnt_max = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int   c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic c_idle    = (KEY_ACTIVE_LOW != 0);
  localparam logic c_press   = ~c_idle;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cnt_max - 1);

`ifdef KEY_LONG_PRESS_EN
  localparam int c_long_max = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int c_long_w   = $clog2(c_long_max + 1);
  // The long counter parks at c_long_sat after firing, which is what
  // limits key_long to a single pulse per press.
  localparam logic [c_long_w-1:0] c_long_last = c_long_w'(c_long_max - 1);
  localparam logic [c_long_w-1:0] c_long_sat  = c_long_w'(c_long_max);
`endif

  // A filter shorter than two cycles cannot distinguish bounce from a press.
  if (c_cnt_max < 2) begin : g_cnt_max_check
    $error("key_debounce: CLK_FREQ_HZ=%0d DEBOUNCE_MS=%0d LONG_MS=%0d gives CNT_MAX=%0d (< 2)",
           CLK_FREQ_HZ, DEBOUNCE_MS, LONG_MS, c_cnt_max);
  end

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_FILT = 2'd1,
    S_HELD       = 2'd2,
    S_REL_FILT   = 2'd3
  } state_t;

  // rst_n deassertion is expected to be aligned to clk by the board-level
  // reset generator, so it is used directly as the async clear.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic [1:0]         r_sync;
    logic               w_key_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_out;
    logic               w_out_nxt;
    logic               r_press;
    logic               w_press_nxt;
    logic               r_rel;
    logic               w_rel_nxt;

    assign w_key_s = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync  <= {2{c_idle}};
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_out   <= c_idle;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], key_in[i]};
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_out   <= w_out_nxt;
        r_press <= w_press_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    // Every state change clears the counter, so it never exceeds CNT_MAX-1.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_key_s == c_press) begin
            w_state_nxt = S_PRESS_FILT;
            w_cnt_nxt   = '0;
          end
        end
        S_PRESS_FILT: begin
          if (w_key_s != c_press) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_cnt_last) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
            w_out_nxt   = c_press;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
        S_HELD: begin
          if (w_key_s == c_idle) begin
            w_state_nxt = S_REL_FILT;
            w_cnt_nxt   = '0;
          end
        end
        S_REL_FILT: begin
          if (w_key_s != c_idle) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_cnt_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_out_nxt   = c_idle;
            w_rel_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign key_out[i]     = r_out;
    assign key_press[i]   = r_press;
    assign key_release[i] = r_rel;

`ifdef KEY_LONG_PRESS_EN
    logic [c_long_w-1:0] r_lcnt;
    logic [c_long_w-1:0] w_lcnt_nxt;
    logic                r_long;
    logic                w_long_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lcnt <= '0;
        r_long <= 1'b0;
      end else begin
        r_lcnt <= w_lcnt_nxt;
        r_long <= w_long_nxt;
      end
    end

    // Cleared on entry to HELD from a new press and on an accepted release.
    // A release bounce (REL_FILT back to HELD) keeps the count running.
    always_comb begin
      w_lcnt_nxt = r_lcnt;
      w_long_nxt = 1'b0;
      if (r_state == S_PRESS_FILT && w_state_nxt == S_HELD) begin
        w_lcnt_nxt = '0;
      end else if (r_state == S_REL_FILT && w_state_nxt == S_IDLE) begin
        w_lcnt_nxt = '0;
      end else if (r_state == S_HELD) begin
        if (r_lcnt == c_long_last) begin
          w_long_nxt = 1'b1;
          w_lcnt_nxt = c_long_sat;
        end else if (r_lcnt != c_long_sat) begin
          w_lcnt_nxt = r_lcnt + c_long_w'(1);
        end
      end
    end

    assign key_long[i] = r_long;
`endif
  end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-channel push-button conditioner that sits directly upstream of the key-driven combinational logic stage (key1/key2 -> led).
- Synchronises raw board key pins to the system clock and rejects contact bounce.
- Emits clean debounced levels in pin polarity, so the downstream gate connects unchanged, plus single-cycle press and release event pulses for future sequential consumers.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
- DEBOUNCE_MS, 20, required stable time in ms. Derived CNT_MAX = CLK_FREQ_HZ/1000*DEBOUNCE_MS. Elaboration fails if CNT_MAX < 2.
- KEY_NUM, 2, number of independent key channels.
- KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- LONG_MS, 1000, long-press threshold in ms. Used only with the optional feature. Derived LONG_MAX = CLK_FREQ_HZ/1000*LONG_MS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset. Asserts immediately, releases synchronously to clk.
- key_in  input  KEY_NUM  raw asynchronous key pins.
- key_out  output  KEY_NUM  debounced key level, same polarity as key_in.
- key_press  output  KEY_NUM  1-cycle pulse when a press is accepted.
- key_release  output  KEY_NUM  1-cycle pulse when a release is accepted.
- key_long  output  KEY_NUM  1-cycle long-press pulse. Present only with KEY_LONG_PRESS_EN.

Behaviour:
- Reset values: key_out = idle level (all 1s if KEY_ACTIVE_LOW=1, else all 0s). key_press, key_release and key_long = 0. Sync flops = idle level. Counters = 0. FSM = IDLE.
- Synchronisation: each key_in bit passes through 2 flops to give key_s. Only key_s is used by the FSM.
- Channels are fully independent. Each has its own FSM and its own counter of width $clog2(CNT_MAX+1).
- FSM states and transitions, per channel:
  - IDLE: key_s = idle level. If key_s = pressed level -> PRESS_FILT, cnt = 0.
  - PRESS_FILT: key_s = pressed level -> cnt++. key_s back to idle level -> IDLE, cnt = 0 (bounce rejected, no pulse). cnt = CNT_MAX-1 with key_s still pressed -> HELD. On the transition cycle, key_out takes the pressed level and key_press = 1 for exactly one cycle.
  - HELD: key_s = idle level -> REL_FILT, cnt = 0.
  - REL_FILT: key_s = idle level -> cnt++. key_s back to pressed level -> HELD, cnt = 0. cnt = CNT_MAX-1 with key_s still idle -> IDLE. On the transition cycle, key_out takes the idle level and key_release = 1 for exactly one cycle.
- Latency: a clean pin edge appears on key_out and the matching pulse exactly CNT_MAX+2 clk cycles after the first rising edge that samples the new level (2 sync cycles + CNT_MAX filter cycles).
- Pulse rules:
  - key_press and key_release are never high in the same cycle for one channel.
  - Pulses are registered outputs, with no combinational path from key_in.
- Bounce: any glitch shorter than CNT_MAX cycles (after sync) produces no change on any output. Each return to the prior level restarts the filter from 0.
- Simultaneous events: several channels may change or pulse in the same cycle. There is no arbitration.
- Reset mid-operation: rst_n low asynchronously forces all reset values, even during a filter count or while a pulse is high. After release, a key already held is treated as a new press and needs the full CNT_MAX+2 cycles.
- Counter never wraps. It holds at most CNT_MAX-1 and is cleared on every state change.

Optional Feature:
- Macro name: KEY_LONG_PRESS_EN.
- Defined:
  - Each channel has a second counter, width $clog2(LONG_MAX+1), that is cleared on entry to HELD and counts while in HELD.
  - When it reaches LONG_MAX-1, key_long pulses for one cycle and the counter saturates, so there is only one pulse per press.
  - REL_FILT does not clear the long counter. A release bounce that returns to HELD resumes the count, but a fully accepted release clears it.
- Not defined: the key_long port and the long counters do not exist. All other behaviour is identical.

Test Plan:
- Sim params CLK_FREQ_HZ=1_000_000, DEBOUNCE_MS=1, so CNT_MAX=1000.
- Reset: rst_n=0 with key_in=2'b00 -> key_out=2'b11 and all pulses 0. Release rst_n, hold key_in=2'b11 for 5000 cycles -> no pulses.
- Clean press: drive key_in[0]=0 -> key_out[0]=0 and a 1-cycle key_press[0] exactly 1002 cycles later. key_out[1] stays 1.
- Bounce rejection: toggle key_in[0] 0/1 every 300 cycles for 3000 cycles, then hold at 1 -> no pulse and key_out[0]=1 throughout.
- Release and simultaneous keys: press both keys in the same cycle, hold 5000 cycles, release both -> key_press=2'b11 in one cycle, later key_release=2'b11 in one cycle, 1002 cycles after each edge.
- Reset mid-press: press key0, assert rst_n low at filter cycle 500, release rst_n with key still pressed -> key_out[0]=1 during reset, key_press[0] fires 1002 cycles after rst_n release.
- KEY_LONG_PRESS_EN with LONG_MS=5: hold key1 for 12000 cycles -> exactly one key_long[1] pulse, 5000 cycles after key_press[1]. Without the macro, the port is absent and the build is clean.
